// File: rtl/psram_req_arb.sv
// psram_req_arb: two-port request arbiter and transfer scheduler in front of the PSRAM engine.
// Define PSRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module psram_req_arb #(
  parameter int ADDR_W = 24,
  parameter int RECY_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [RECY_W-1:0] recy_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [31:0]       req0_wdata_i,
  output logic              rsp0_valid_o,
  output logic              rsp0_err_o,
  output logic [31:0]       rsp0_rdata_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [31:0]       req1_wdata_i,
  output logic              rsp1_valid_o,
  output logic              rsp1_err_o,
  output logic [31:0]       rsp1_rdata_o,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  output logic              core_we_o,
  output logic [ADDR_W-1:0] core_addr_o,
  output logic [31:0]       core_wdata_o,
  input  logic              core_done_i,
  input  logic [31:0]       core_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RECY} state_t;

  localparam logic [RECY_W-1:0] RECY_ONE = RECY_W'(1);

  state_t              state_q, state_d;
  logic                grant_vld, grant_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic                owner_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [RECY_W-1:0]   recy_cnt_q;
  logic [1:0]          rsp_valid_q, rsp_err_q;
  logic [31:0]         rsp_rdata_q;
`ifndef PSRAM_ARB_FIXED_PRIO_EN
  logic                last_q;  // port granted most recently
`endif

  // Ready is combinational, so it is also held low while reset is asserted.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n_i && state_q == ST_IDLE && en_i && (req0_valid_i || req1_valid_i)) begin
      grant_vld = 1'b1;
      if (req0_valid_i && req1_valid_i) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
        grant_id = 1'b0;
`else
        grant_id = ~last_q;
`endif
      end else begin
        grant_id = req1_valid_i;
      end
    end
  end

  assign sel_we    = grant_id ? req1_we_i    : req0_we_i;
  assign sel_addr  = grant_id ? req1_addr_i  : req0_addr_i;
  assign sel_wdata = grant_id ? req1_wdata_i : req0_wdata_i;

  assign req0_ready_o = grant_vld & ~grant_id;
  assign req1_ready_o = grant_vld &  grant_id;

  // Misaligned requests are answered straight from IDLE with an error response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant_vld && !sel_addr[0]) state_d = ST_ISSUE;
      ST_ISSUE: if (core_ready_i) state_d = ST_WAIT;
      ST_WAIT:  if (core_done_i) state_d = (recy_i != '0) ? ST_RECY : ST_IDLE;
      ST_RECY:  if (recy_cnt_q <= RECY_ONE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      recy_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      state_q     <= state_d;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
      if (grant_vld) begin
        owner_q <= grant_id;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        if (sel_addr[0]) begin
          rsp_valid_q[grant_id] <= 1'b1;
          rsp_err_q[grant_id]   <= 1'b1;
        end
      end
      if (state_q == ST_WAIT && core_done_i) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q          <= we_q ? '0 : core_rdata_i;
        recy_cnt_q           <= recy_i;
      end else if (state_q == ST_RECY) begin
        recy_cnt_q <= recy_cnt_q - RECY_ONE;
      end
    end
  end

`ifndef PSRAM_ARB_FIXED_PRIO_EN
  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (grant_vld) begin
      last_q <= grant_id;
    end
  end
`endif

  assign core_valid_o = (state_q == ST_ISSUE);
  assign core_we_o    = we_q;
  assign core_addr_o  = addr_q;
  assign core_wdata_o = wdata_q;
  assign busy_o       = (state_q != ST_IDLE);

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp0_err_o   = rsp_err_q[0];
  assign rsp0_rdata_o = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp1_err_o   = rsp_err_q[1];
  assign rsp1_rdata_o = rsp_valid_q[1] ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_psram_req_arb.sv
// tb_psram_req_arb: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-timeline model of the arbiter (grant rule, transfer lifetime, response and gap timing).
module tb_psram_req_arb;

`ifdef PSRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        en_i = 1'b0;
  logic [7:0]  recy_i = '0;
  logic        req0_valid_i = 1'b0, req0_we_i = 1'b0;
  logic [23:0] req0_addr_i = '0;
  logic [31:0] req0_wdata_i = '0;
  logic        req1_valid_i = 1'b0, req1_we_i = 1'b0;
  logic [23:0] req1_addr_i = '0;
  logic [31:0] req1_wdata_i = '0;
  logic        core_ready_i = 1'b0, core_done_i = 1'b0;
  logic [31:0] core_rdata_i = '0;
  logic        req0_ready_o, rsp0_valid_o, rsp0_err_o;
  logic        req1_ready_o, rsp1_valid_o, rsp1_err_o;
  logic [31:0] rsp0_rdata_o, rsp1_rdata_o;
  logic        core_valid_o, core_we_o, busy_o;
  logic [23:0] core_addr_o;
  logic [31:0] core_wdata_o;

  psram_req_arb #(.ADDR_W(24), .RECY_W(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .recy_i(recy_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_err_o(rsp0_err_o), .rsp0_rdata_o(rsp0_rdata_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_err_o(rsp1_err_o), .rsp1_rdata_o(rsp1_rdata_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .core_we_o(core_we_o),
    .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_done_i(core_done_i), .core_rdata_i(core_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0, n_pass = 0, cyc = 0;

  // Reference model: one in-flight transfer plus the cycle from which grants are allowed again.
  bit          xf_on, xf_acked, xf_we, xf_owner;
  logic [23:0] xf_addr;
  logic [31:0] xf_wdata;
  int          free_at = 0;
  bit          last_gnt = 1'b1;
  int          rsp_due = -1;
  bit          rsp_port, rsp_err_e;
  logic [31:0] rsp_rdata_e;
  bit          m_hs0, m_hs1;

  // Observation log for directed checks.
  int          obs_gnt[$], gnt_cyc[$];
  int          cv_cnt = 0, rsp0_cyc = -1, rsp1_cyc = -1;
  logic [31:0] rsp0_rd, rsp1_rd;
  logic        rsp0_er, rsp1_er;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  task automatic step();
    bit idle, any, w, exp_cv, due;
    #1;
    idle = !xf_on && (cyc >= free_at);
    any  = idle && en_i && (req0_valid_i || req1_valid_i);
    if (req0_valid_i && req1_valid_i) w = FIXED ? 1'b0 : !last_gnt;
    else                              w = req1_valid_i;
    check("req0_ready", req0_ready_o, any && !w);
    check("req1_ready", req1_ready_o, any && w);
    exp_cv = xf_on && !xf_acked;
    check("core_valid", core_valid_o, exp_cv);
    if (exp_cv) begin
      check("core_we", core_we_o, xf_we);
      check("core_addr", core_addr_o, xf_addr);
      check("core_wdata", core_wdata_o, xf_wdata);
    end
    due = (rsp_due == cyc);
    check("rsp0_valid", rsp0_valid_o, due && !rsp_port);
    check("rsp1_valid", rsp1_valid_o, due && rsp_port);
    if (due) begin
      check("rsp_err", rsp_port ? rsp1_err_o : rsp0_err_o, rsp_err_e);
      check("rsp_rdata", rsp_port ? rsp1_rdata_o : rsp0_rdata_o, rsp_rdata_e);
    end
    check("busy", busy_o, xf_on || (cyc < free_at));

    if (req0_valid_i && req0_ready_o) begin obs_gnt.push_back(0); gnt_cyc.push_back(cyc); end
    if (req1_valid_i && req1_ready_o) begin obs_gnt.push_back(1); gnt_cyc.push_back(cyc); end
    if (core_valid_o) cv_cnt++;
    if (rsp0_valid_o) begin rsp0_cyc = cyc; rsp0_rd = rsp0_rdata_o; rsp0_er = rsp0_err_o; end
    if (rsp1_valid_o) begin rsp1_cyc = cyc; rsp1_rd = rsp1_rdata_o; rsp1_er = rsp1_err_o; end

    m_hs0 = any && !w;
    m_hs1 = any && w;
    if (any) begin
      last_gnt = w;
      if ((w ? req1_addr_i[0] : req0_addr_i[0])) begin
        rsp_due = cyc + 1; rsp_port = w; rsp_err_e = 1'b1; rsp_rdata_e = '0;
      end else begin
        xf_on = 1'b1; xf_acked = 1'b0; xf_owner = w;
        xf_we    = w ? req1_we_i    : req0_we_i;
        xf_addr  = w ? req1_addr_i  : req0_addr_i;
        xf_wdata = w ? req1_wdata_i : req0_wdata_i;
      end
    end else if (exp_cv && core_ready_i) begin
      xf_acked = 1'b1;
    end else if (xf_on && xf_acked && core_done_i) begin
      xf_on = 1'b0;
      rsp_due = cyc + 1; rsp_port = xf_owner; rsp_err_e = 1'b0;
      rsp_rdata_e = xf_we ? 32'h0 : core_rdata_i;
      free_at = cyc + 1 + int'(recy_i);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks outputs are cleared at once, releases on the next falling edge.
  task automatic do_reset();
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_ready", {req0_ready_o, req1_ready_o}, 2'b00);
    check("rst_core", {core_valid_o, core_we_o, core_addr_o, core_wdata_o}, 58'h0);
    check("rst_rsp0", {rsp0_valid_o, rsp0_err_o, rsp0_rdata_o}, 34'h0);
    check("rst_rsp1", {rsp1_valid_o, rsp1_err_o, rsp1_rdata_o}, 34'h0);
    check("rst_busy", busy_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    xf_on = 1'b0; xf_acked = 1'b0; free_at = 0; last_gnt = 1'b1; rsp_due = -1;
    m_hs0 = 1'b0; m_hs1 = 1'b0; rsp0_cyc = -1; rsp1_cyc = -1;
    cyc++;
  endtask

  task automatic new_req(input bit p);
    logic [23:0] a;
    a = 24'($urandom);
    a[0] = ($urandom_range(0, 4) == 0);
    if (!p) begin
      req0_valid_i = 1'b1; req0_we_i = 1'($urandom); req0_addr_i = a; req0_wdata_i = $urandom;
    end else begin
      req1_valid_i = 1'b1; req1_we_i = 1'($urandom); req1_addr_i = a; req1_wdata_i = $urandom;
    end
  endtask

  initial begin
    int t0, g, n0, nb, cv_mark, r_mark, ga, gb;
    do_reset();

    // Single port 0 read, immediate engine, zero recovery.
    en_i = 1'b1; recy_i = 8'd0; core_ready_i = 1'b1; core_done_i = 1'b1;
    core_rdata_i = 32'hDEADBEEF;
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_addr_i = 24'h000010;
    t0 = cyc;
    step();
    req0_valid_i = 1'b0;
    repeat (4) step();
    check("s1_latency", rsp0_cyc - t0, 3);
    check("s1_rdata", rsp0_rd, 32'hDEADBEEF);
    check("s1_err", rsp0_er, 1'b0);
    check("s1_busy_after", busy_o, 1'b0);

    // Both ports valid continuously from reset: grant order.
    do_reset();
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_addr_i = 24'h000100;
    req1_valid_i = 1'b1; req1_we_i = 1'b1; req1_addr_i = 24'h000200; req1_wdata_i = 32'hA5A5_0001;
    nb = obs_gnt.size();
    for (int i = 0; i < 80 && obs_gnt.size() < nb + 4; i++) step();
    check("s2_count", obs_gnt.size() >= nb + 4, 1'b1);
    for (int k = 0; k < 4; k++)
      check("s2_order", (obs_gnt.size() > nb + k) ? obs_gnt[nb + k] : 9, FIXED ? 0 : (k % 2));

    // Misaligned port 1 write: accepted, error next cycle, no core transfer.
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    repeat (8) step();
    cv_mark = cv_cnt;
    req1_valid_i = 1'b1; req1_we_i = 1'b1; req1_addr_i = 24'h000003; req1_wdata_i = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin step(); if (m_hs1) break; end
    req1_valid_i = 1'b0;
    g = gnt_cyc[$];
    repeat (3) step();
    check("s3_gnt_port", obs_gnt[$], 1);
    check("s3_rsp_cycle", rsp1_cyc - g, 1);
    check("s3_err", rsp1_er, 1'b1);
    check("s3_rdata", rsp1_rd, 32'h0);
    check("s3_no_core", cv_cnt - cv_mark, 0);

    // Recovery gap of 5 between back-to-back port 0 reads.
    recy_i = 8'd5;
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_addr_i = 24'h000020;
    n0 = gnt_cyc.size();
    for (int i = 0; i < 40 && gnt_cyc.size() < n0 + 2; i++) step();
    req0_valid_i = 1'b0; recy_i = 8'd0;
    ga = (gnt_cyc.size() > n0)     ? gnt_cyc[n0]     : -100;
    gb = (gnt_cyc.size() > n0 + 1) ? gnt_cyc[n0 + 1] : -100;
    check("s4_recy_gap", gb - rsp0_cyc, 5);
    check("s4_grant_spacing", gb - ga, 8);
    repeat (12) step();

    // Engine stalls ready for 3 cycles; en_i drops during WAIT.
    core_ready_i = 1'b0; core_done_i = 1'b0;
    req0_valid_i = 1'b1; req0_we_i = 1'b1; req0_addr_i = 24'h000040; req0_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin step(); if (m_hs0) break; end
    req0_valid_i = 1'b0;
    cv_mark = cv_cnt;
    repeat (3) step();
    core_ready_i = 1'b1;
    step();
    core_ready_i = 1'b0; en_i = 1'b0;
    step();
    check("s5_valid_hold", cv_cnt - cv_mark, 4);
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_addr_i = 24'h000044;
    r_mark = rsp0_cyc;
    repeat (2) step();
    core_done_i = 1'b1;
    step();
    core_done_i = 1'b0;
    nb = gnt_cyc.size();
    repeat (5) step();
    check("s5_rsp_seen", rsp0_cyc > r_mark, 1'b1);
    check("s5_no_grant", gnt_cyc.size(), nb);
    en_i = 1'b1;
    step();
    check("s5_grant_on_en", gnt_cyc.size(), nb + 1);

    // Reset while in WAIT, with both ports pending afterwards.
    req0_valid_i = 1'b0; core_ready_i = 1'b1;
    step();
    core_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_addr_i = 24'h000080;
    req1_valid_i = 1'b1; req1_we_i = 1'b0; req1_addr_i = 24'h000090;
    do_reset();
    core_ready_i = 1'b1; core_done_i = 1'b1;
    nb = obs_gnt.size();
    step();
    check("s6_first_grant", (obs_gnt.size() > nb) ? obs_gnt[nb] : 9, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (m_hs0 || !req0_valid_i) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b0); else req0_valid_i = 1'b0;
      end
      if (m_hs1 || !req1_valid_i) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b1); else req1_valid_i = 1'b0;
      end
      en_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) recy_i = 8'($urandom_range(0, 3));
      core_ready_i = 1'($urandom);
      core_done_i  = 1'($urandom);
      core_rdata_i = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psram_req_arb.md
Name: psram_req_arb

Overview:
- Two-port request arbiter and transfer scheduler in front of the PSRAM transfer engine.
- Accepts single 32-bit read/write requests from two independent requesters, e.g. instruction fetch (port 0) and data (port 1).
- Grants one request at a time, by round-robin or by fixed priority.
- Issues the granted request to the engine, returns the response to the owning port, and enforces a programmable idle recovery gap between transfers.

Parameters:
ADDR_W, 24, width of PSRAM byte address carried on request and core interfaces
RECY_W, 8, width of recovery-cycle count (matches CTRL.RECY field)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  CTRL.EN; 0 blocks new grants
recy_i  in  RECY_W  recovery idle cycles inserted after each transfer
req0_valid_i  in  1  port 0 request valid
req0_ready_o  out  1  port 0 request accepted
req0_we_i  in  1  port 0 write(1)/read(0)
req0_addr_i  in  ADDR_W  port 0 byte address
req0_wdata_i  in  32  port 0 write data
rsp0_valid_o  out  1  port 0 response pulse
rsp0_err_o  out  1  port 0 response error (misaligned)
rsp0_rdata_o  out  32  port 0 read data
req1_* / rsp1_*  same as port 0  port 1 equivalents
core_valid_o  out  1  transfer request to engine
core_ready_i  in  1  engine accepted transfer
core_we_o  out  1  latched direction
core_addr_o  out  ADDR_W  latched address
core_wdata_o  out  32  latched write data
core_done_i  in  1  engine completed transfer (CE deasserted)
core_rdata_i  in  32  read data, valid with core_done_i
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous, active-low, on rst_n_i.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - RR pointer = 1, so port 0 wins the first tie.
  - Recovery counter 0.
- FSM states: IDLE, ISSUE, WAIT, RECY.
- IDLE:
  - If en_i=1 and any reqN_valid_i=1, choose a winner. If both are valid, grant the port not granted last; otherwise grant the single valid port.
  - reqN_ready_o is combinational, high only for the winner, and only in IDLE. Handshake is valid&&ready.
  - On handshake: latch we/addr/wdata and the owner id, update the RR pointer.
  - Next state: ISSUE, or the error path if misaligned.
- Misaligned request (addr[0]=1; OPI bursts must start on an even address):
  - The request is accepted.
  - Next cycle: rspN_valid_o=1, rspN_err_o=1, rdata=0.
  - Stay in IDLE, no core transfer, no recovery gap.
- ISSUE:
  - core_valid_o=1 with latched fields, held stable until core_ready_i.
  - On core_ready_i, go to WAIT. core_valid_o drops the next cycle.
- WAIT:
  - On core_done_i, capture core_rdata_i (reads only; writes return 0).
  - Next cycle: owner's rspN_valid_o=1 for exactly 1 cycle, err=0.
  - Next state: RECY if recy_i!=0, else IDLE.
- RECY:
  - Counter loads recy_i on entry and decrements each cycle.
  - Return to IDLE when it reaches 1, giving exactly recy_i cycles in RECY.
  - No grants during RECY.
- Minimum latency, read with core_ready_i/core_done_i immediate: accept at cycle 0, core_valid_o at cycle 1, done at cycle 2, rsp at cycle 3.
- en_i deassert mid-transfer:
  - The in-flight transfer completes normally.
  - Grants are blocked only in IDLE.
- core_done_i outside WAIT is ignored. core_ready_i outside ISSUE is ignored.
- Requests that are not granted must be held by the requester; the arbiter never drops them.
- Reset mid-transfer: immediate return to IDLE, all outputs 0, no response issued.
- rsp0_valid_o and rsp1_valid_o are never high in the same cycle.

Optional Feature:
- Macro: PSRAM_ARB_FIXED_PRIO_EN.
- When defined: port 0 always wins a tie, and the RR pointer is unused.
- When undefined: round-robin as described above.
- All other behaviour is identical.

Test Plan:
- Single port 0 read, addr 0x000010, recy_i=0, core_ready/done immediate, core_rdata_i=0xDEADBEEF -> core_valid_o at cycle 1 with addr 0x10, we=0; rsp0_valid_o one pulse with rdata 0xDEADBEEF, err=0; busy_o low after.
- Both ports valid continuously, 4 transfers, round-robin build -> grant order 0,1,0,1. Fixed-priority build -> 0,0,0,0 while port 0 is still valid.
- Port 1 write, addr 0x000003 -> req1_ready_o high, no core_valid_o, rsp1_valid_o with err=1 one cycle after accept.
- recy_i=5, back-to-back port 0 requests -> exactly 5 cycles in RECY between core_done_i and the next req0_ready_o; no grant during RECY.
- core_ready_i delayed 3 cycles -> core_valid_o and fields held stable for 4 cycles; en_i=0 during WAIT -> transfer still completes and responds, then no new grant until en_i=1.
- rst_n_i asserted in WAIT -> all outputs 0 immediately; after release, a pending port 0 request is granted first and no stale response appears.
